// File: rtl/pc_pkg.sv
// Shared definitions for the PC / branch unit: FSM state encoding,
// instruction size, default reset vector and an alignment helper.
package pc_pkg;

  // Fetch FSM states
  typedef enum logic [1:0] {
    RST_S = 2'b00,
    FETCH = 2'b01,
    REDIR = 2'b10,
    HALT  = 2'b11
  } pc_state_e;

  localparam logic [31:0] INSTR_BYTES          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // Force an address onto a 4-byte instruction boundary
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/branch_adder.sv
// Branch / jump target computation. Conditional branches and JAL use
// branch_pc + offset; JALR uses jalr_base + offset with bit 0 cleared.
// Purely combinational, 32-bit wrapping add.
module branch_adder (
  input  logic [31:0] branch_pc,
  input  logic [31:0] jalr_base,
  input  logic [31:0] offset,
  input  logic        jalr_en,
  output logic [31:0] target
);

  logic [31:0] base_s;
  logic [31:0] sum_s;

  // Select the base, add the offset and apply the JALR bit-0 clear
  always_comb begin
    if (jalr_en) begin
      base_s = jalr_base;
    end else begin
      base_s = branch_pc;
    end
    sum_s = base_s + offset;
    if (jalr_en) begin
      target = {sum_s[31:1], 1'b0};
    end else begin
      target = sum_s;
    end
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter and branch redirect unit.
// FSM RST_S -> FETCH; a taken branch loads the target and spends one
// cycle in REDIR (FLUSH=1, no fetch request) before fetching again.
// Optional feature macro: PC_MISALIGN_TRAP_EN -- when defined, a target
// with bit 1 set is not loaded; the unit raises MISALIGNED and parks in
// HALT until RESET. When undefined, targets are word-aligned silently.
// All outputs are registered.
module pc_branch_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        INSTR_ACK,
  input  logic        BRANCH_TAKEN,
  input  logic        JALR_EN,
  input  logic [31:0] BRANCH_PC,
  input  logic [31:0] JALR_BASE,
  input  logic [31:0] BRANCH_OFFSET,
  output logic [31:0] PC,
  output logic        PC_REQ,
  output logic [31:0] PC_PLUS4,
  output logic        FLUSH,
  output logic        MISALIGNED
);

  pc_state_e   state_r;
  pc_state_e   state_next_s;
  logic [31:0] pc_r;
  logic [31:0] pc_next_s;
  logic [31:0] pc_plus4_r;
  logic        pc_req_r;
  logic        flush_r;
  logic        misaligned_r;
  logic [31:0] target_s;

  branch_adder u_branch_adder (
    .branch_pc (BRANCH_PC),
    .jalr_base (JALR_BASE),
    .offset    (BRANCH_OFFSET),
    .jalr_en   (JALR_EN),
    .target    (target_s)
  );

  // Next-state and next-PC selection; a taken branch beats stall and ack
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    case (state_r)
      RST_S: begin
        state_next_s = FETCH;
      end
      FETCH: begin
        if (BRANCH_TAKEN) begin
`ifdef PC_MISALIGN_TRAP_EN
          if (target_s[1]) begin
            state_next_s = HALT;
            pc_next_s    = pc_r;
          end else begin
            state_next_s = REDIR;
            pc_next_s    = word_align(target_s);
          end
`else
          state_next_s = REDIR;
          pc_next_s    = word_align(target_s);
`endif
        end else if (INSTR_ACK && !STALL) begin
          state_next_s = FETCH;
          pc_next_s    = pc_r + INSTR_BYTES;
        end else begin
          state_next_s = FETCH;
          pc_next_s    = pc_r;
        end
      end
      REDIR: begin
        // Branch inputs are ignored while the redirect bubble drains
        state_next_s = FETCH;
      end
      HALT: begin
        state_next_s = HALT;
      end
      default: begin
        state_next_s = RST_S;
        pc_next_s    = RESET_VECTOR;
      end
    endcase
  end

  // State, PC and registered output flags; RESET overrides every state
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r      <= RST_S;
      pc_r         <= RESET_VECTOR;
      pc_plus4_r   <= RESET_VECTOR + INSTR_BYTES;
      pc_req_r     <= 1'b0;
      flush_r      <= 1'b0;
      misaligned_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      pc_r         <= pc_next_s;
      pc_plus4_r   <= pc_next_s + INSTR_BYTES;
      pc_req_r     <= (state_next_s == FETCH);
      flush_r      <= (state_next_s == REDIR);
      misaligned_r <= (state_next_s == HALT);
    end
  end

  assign PC         = pc_r;
  assign PC_PLUS4   = pc_plus4_r;
  assign PC_REQ     = pc_req_r;
  assign FLUSH      = flush_r;
  assign MISALIGNED = misaligned_r;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed, table-driven bench for pc_branch_unit. Each record gives the
// inputs for one clock and the outputs expected just after that edge.
// Expectations follow PC_MISALIGN_TRAP_EN when it is defined.
module tb_pc_branch_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        STALL;
  logic        INSTR_ACK;
  logic        BRANCH_TAKEN;
  logic        JALR_EN;
  logic [31:0] BRANCH_PC;
  logic [31:0] JALR_BASE;
  logic [31:0] BRANCH_OFFSET;
  logic [31:0] PC;
  logic        PC_REQ;
  logic [31:0] PC_PLUS4;
  logic        FLUSH;
  logic        MISALIGNED;

  int checks = 0;
  int errors = 0;

  pc_branch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .STALL         (STALL),
    .INSTR_ACK     (INSTR_ACK),
    .BRANCH_TAKEN  (BRANCH_TAKEN),
    .JALR_EN       (JALR_EN),
    .BRANCH_PC     (BRANCH_PC),
    .JALR_BASE     (JALR_BASE),
    .BRANCH_OFFSET (BRANCH_OFFSET),
    .PC            (PC),
    .PC_REQ        (PC_REQ),
    .PC_PLUS4      (PC_PLUS4),
    .FLUSH         (FLUSH),
    .MISALIGNED    (MISALIGNED)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        ack;
    logic        taken;
    logic        jalr;
    logic [31:0] bpc;
    logic [31:0] base;
    logic [31:0] off;
    logic [31:0] epc;
    logic [31:0] eplus4;
    logic        ereq;
    logic        eflush;
    logic        emis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic rst, logic stall, logic ack, logic taken,
                             logic jalr, logic [31:0] bpc, logic [31:0] base,
                             logic [31:0] off, logic [31:0] epc, logic ereq,
                             logic eflush, logic emis);
    vec_t r;
    r.rst = rst; r.stall = stall; r.ack = ack; r.taken = taken; r.jalr = jalr;
    r.bpc = bpc; r.base = base; r.off = off;
    r.epc = epc; r.eplus4 = epc + 32'd4;
    r.ereq = ereq; r.eflush = eflush; r.emis = emis;
    return r;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    RESET = x.rst; STALL = x.stall; INSTR_ACK = x.ack;
    BRANCH_TAKEN = x.taken; JALR_EN = x.jalr;
    BRANCH_PC = x.bpc; JALR_BASE = x.base; BRANCH_OFFSET = x.off;
  endtask

  task automatic check_all(input vec_t x, input int idx);
    chk("pc",         idx, PC,                 x.epc);
    chk("pc_plus4",   idx, PC_PLUS4,           x.eplus4);
    chk("pc_req",     idx, {31'd0, PC_REQ},    {31'd0, x.ereq});
    chk("flush",      idx, {31'd0, FLUSH},     {31'd0, x.eflush});
    chk("misaligned", idx, {31'd0, MISALIGNED},{31'd0, x.emis});
  endtask

  initial begin
    //                 rst   stl   ack   tkn   jalr  bpc           base          off           epc           req   flush mis
    // reset state, then the first fetches (0x0, 0x4, 0x8)
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0));
    vecs.push_back(v(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0));
    vecs.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 1'b0));
    vecs.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h4,        1'b1, 1'b0, 1'b0));
    vecs.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h8,        1'b1, 1'b0, 1'b0));
    // stall holds, missing ack holds
    vecs.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h8,        1'b1, 1'b0, 1'b0));
    vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h8,        1'b1, 1'b0, 1'b0));
    // branch to 0x100, then a taken branch during REDIR is ignored
    vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8,        32'h0,        32'hF8,       32'h100,      1'b0, 1'b1, 1'b0));
    vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        32'h40,       32'h100,      1'b1, 1'b0, 1'b0));
    // backward branch 0xF8 + (-16) = 0xE8
    vecs.push_back(v(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hF8,       32'h0,        32'hFFFF_FFF0,32'hE8,       1'b0, 1'b1, 1'b0));
    vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'hE8,       1'b1, 1'b0, 1'b0));
    vecs.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'hEC,       1'b1, 1'b0, 1'b0));
    // JALR under stall: 0x2001 + 4 = 0x2005, bit0 cleared -> 0x2004
    vecs.push_back(v(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h500,      32'h2001,     32'h4,        32'h2004,     1'b0, 1'b1, 1'b0));
    vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h2004,     1'b1, 1'b0, 1'b0));
    // JALR 0x2000 + (-3) = 0x1FFD -> 0x1FFC
    vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h2000,     32'hFFFF_FFFD,32'h1FFC,     1'b0, 1'b1, 1'b0));
    vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h1FFC,     1'b1, 1'b0, 1'b0));
    // jump to the top word, PC_PLUS4 wraps, then the PC itself wraps
    vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        32'hFFFF_FFFC,32'hFFFF_FFFC,1'b0, 1'b1, 1'b0));
    vecs.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'hFFFF_FFFC,1'b1, 1'b0, 1'b0));
    vecs.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 1'b0));
`ifdef PC_MISALIGN_TRAP_EN
    // target 0x102 traps: PC held, HALT until reset
    vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100,      32'h0,        32'h2,        32'h0,        1'b0, 1'b0, 1'b1));
    vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b1));
    vecs.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b1));
    vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        32'h200,      32'h0,        1'b0, 1'b0, 1'b1));
`else
    // target 0x102 is aligned down to 0x100
    vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100,      32'h0,        32'h2,        32'h100,      1'b0, 1'b1, 1'b0));
    vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h100,      1'b1, 1'b0, 1'b0));
    vecs.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h104,      1'b1, 1'b0, 1'b0));
    vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        32'h200,      32'h200,      1'b0, 1'b1, 1'b0));
`endif
    // reset while in REDIR (or HALT with the trap), then restart
    vecs.push_back(v(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0));
    vecs.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 1'b0));
    vecs.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h4,        1'b1, 1'b0, 1'b0));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge CLK);
      #1;
      check_all(vecs[i], i);
    end

    // Hand sequence: reset, a stall run at the reset vector, then a
    // stream of acked fetches advancing by one word each cycle
    RESET = 1'b1; STALL = 1'b0; INSTR_ACK = 1'b0; BRANCH_TAKEN = 1'b0;
    JALR_EN = 1'b0; BRANCH_PC = 32'h0; JALR_BASE = 32'h0; BRANCH_OFFSET = 32'h0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;
    STALL = 1'b1; INSTR_ACK = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk("stall_pc",  100 + i, PC, 32'h0);
      chk("stall_req", 100 + i, {31'd0, PC_REQ}, 32'd1);
    end
    STALL = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge CLK); #1;
      chk("stream_pc",    200 + i, PC,       32'd4 * i);
      chk("stream_plus4", 200 + i, PC_PLUS4, 32'd4 * i + 32'd4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
